// File: rtl/riscv_pkg.sv
// Shared core types plus configuration helpers for the pipelined adder.
package riscv_pkg;

  // Core datapath word.
  typedef logic [31:0] data_t;

  // Default pipeline depth of the execute-stage adder.
  localparam int unsigned ADDER_DEFAULT_STAGES = 4;

  // A split is legal when there is at least one stage and every chunk has the same width.
  function automatic bit adder_cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_carry_adder_chunk.sv
// adder_chunk: combinational CW-bit slice of the pipelined adder.
// Exports the carry out of the slice and the carry into its top bit, so the
// last slice can form signed overflow.
module adder_chunk #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          c_i,
  output logic [CW-1:0] sum_o,
  output logic          c_o,
  output logic          c_msb_o
);

  logic [CW:0] full_w;

  assign full_w  = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};
  assign sum_o   = full_w[CW-1:0];
  assign c_o     = full_w[CW];
  // The sum bit is a ^ b ^ carry-in, so the carry into the top bit falls out by xor.
  assign c_msb_o = a_i[CW-1] ^ b_i[CW-1] ^ full_w[CW-1];

endmodule

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/subtract split into STAGES equal chunks,
// one chunk per pipeline stage, carry registered between stages. Global stall
// (advance = !valid_o | ready_i), one-cycle flush of all in-flight operations.
// Optional: define PIPE_ADDER_TAG_EN to carry a TAG_WIDTH-bit tag with each op.
module pipelined_carry_adder
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH  = $bits(data_t),
  parameter int unsigned STAGES = ADDER_DEFAULT_STAGES
`ifdef PIPE_ADDER_TAG_EN
  ,
  parameter int unsigned TAG_WIDTH = 4
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             inv_b_i,
  input  logic             carry_in_i,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  output logic             valid_o,
  input  logic             ready_i,
`ifdef PIPE_ADDER_TAG_EN
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic [TAG_WIDTH-1:0] tag_o,
`endif
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             overflow_o
);

  localparam int unsigned CW = (STAGES >= 1) ? (WIDTH / STAGES) : WIDTH;

  // Per-stage state. word holds finished result chunks in its low bits and the
  // still-unconsumed chunks of operand A above them, so A's remainder and the
  // finished result share one register. B's remainder shrinks per stage and
  // lives in gen_brem.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] word;
  } adder_stage_t;

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  if (!adder_cfg_ok(WIDTH, STAGES)) begin : gen_bad_cfg
    $error("pipelined_carry_adder: STAGES must be >= 1 and divide WIDTH exactly");
  end

  assign b_eff   = data_b_i ^ {WIDTH{inv_b_i}};
  assign advance = ~valid_o | ready_i;
  assign ready_o = advance;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : gen_stage
    localparam int unsigned LO   = gi * CW;
    localparam int unsigned IN_W = WIDTH - LO;

    adder_stage_t     st_q;
    adder_stage_t     st_d;
    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:0] word_in;
    logic [IN_W-1:0]  b_src;
    logic [CW-1:0]    sum_w;
    logic             cout_w;
    logic             cmsb_w;
`ifdef PIPE_ADDER_TAG_EN
    logic [TAG_WIDTH-1:0] tag_src;
    logic [TAG_WIDTH-1:0] tag_q;
`endif

    if (gi == 0) begin : gen_head
      assign v_in    = valid_i;
      assign c_in    = carry_in_i;
      assign word_in = data_a_i;
      assign b_src   = b_eff;
`ifdef PIPE_ADDER_TAG_EN
      assign tag_src = tag_i;
`endif
    end else begin : gen_link
      assign v_in    = gen_stage[gi-1].st_q.valid;
      assign c_in    = gen_stage[gi-1].st_q.carry;
      assign word_in = gen_stage[gi-1].st_q.word;
      assign b_src   = gen_stage[gi-1].gen_brem.b_rem_q;
`ifdef PIPE_ADDER_TAG_EN
      assign tag_src = gen_stage[gi-1].tag_q;
`endif
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .a_i     (word_in[LO +: CW]),
      .b_i     (b_src[CW-1:0]),
      .c_i     (c_in),
      .sum_o   (sum_w),
      .c_o     (cout_w),
      .c_msb_o (cmsb_w)
    );

    // Next state: this stage's chunk of the word is replaced by its sum.
    always_comb begin
      st_d.valid         = v_in;
      st_d.carry         = cout_w;
      st_d.word          = word_in;
      st_d.word[LO +: CW] = sum_w;
    end

    // Valid bit follows the global stall and flush; data loads only on a valid advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st_q <= '0;
      end else begin
        if (flush_i) begin
          st_q.valid <= 1'b0;
        end else if (advance) begin
          st_q.valid <= st_d.valid;
        end
        if (advance && v_in) begin
          st_q.carry <= st_d.carry;
          st_q.word  <= st_d.word;
        end
      end
    end

    if (gi < STAGES - 1) begin : gen_brem
      logic [IN_W-CW-1:0] b_rem_q;
      // Keep only the B chunks later stages still need.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          b_rem_q <= '0;
        end else if (advance && v_in) begin
          b_rem_q <= b_src[IN_W-1:CW];
        end
      end
    end

    if (gi == STAGES - 1) begin : gen_tail
      logic ovf_q;
      // Signed overflow of the whole word comes from the top chunk only.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ovf_q <= 1'b0;
        end else if (advance && v_in) begin
          ovf_q <= cout_w ^ cmsb_w;
        end
      end
    end else begin : gen_mid
      logic unused_cmsb_w;
      assign unused_cmsb_w = cmsb_w;
    end

`ifdef PIPE_ADDER_TAG_EN
    // The tag rides along with its operation under the same load condition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        tag_q <= '0;
      end else if (advance && v_in) begin
        tag_q <= tag_src;
      end
    end
`endif
  end

  assign valid_o     = gen_stage[STAGES-1].st_q.valid;
  assign result_o    = gen_stage[STAGES-1].st_q.word;
  assign carry_out_o = gen_stage[STAGES-1].st_q.carry;
  assign overflow_o  = gen_stage[STAGES-1].gen_tail.ovf_q;
`ifdef PIPE_ADDER_TAG_EN
  assign tag_o       = gen_stage[STAGES-1].tag_q;
`endif

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
Parametrised, pipelined successor to the single-cycle ripple carry adder.
- Splits a WIDTH-bit add/subtract into STAGES equal chunks, one chunk per pipeline stage; the carry is registered between stages.
- Operands are skewed on entry and results deskewed on exit.
- Accepts one operation per cycle under a valid/ready handshake.
- Used by the execute stage for wide or high-frequency add/sub where one ripple chain across WIDTH misses timing.

Parameters:
- WIDTH, $bits(riscv_pkg::data_t), operand/result width in bits.
- STAGES, 4, pipeline depth = number of chunks. Must be >=1 and divide WIDTH exactly; otherwise $error at elaboration.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  discard all in-flight operations.
- valid_i  in  1  input operation valid.
- ready_o  out  1  pipeline can accept input this cycle.
- inv_b_i  in  1  invert data_b_i before adding (subtract when used with carry_in_i=1).
- carry_in_i  in  1  carry into bit 0.
- data_a_i  in  WIDTH  operand A.
- data_b_i  in  WIDTH  operand B.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- result_o  out  WIDTH  sum, modulo 2^WIDTH.
- carry_out_o  out  1  carry out of the MSB.
- overflow_o  out  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- One clock domain; reset is asynchronous and active-low. The clock is clk_i and the reset is rst_ni.
- Reset values:
  - all stage valid bits 0, so valid_o=0;
  - result_o, carry_out_o, overflow_o all 0;
  - ready_o=1 once out of reset.
- Chunk size CW = WIDTH/STAGES. Stage k adds bits [k*CW +: CW] using the registered carry from stage k-1; stage 0 uses carry_in_i. inv_b_i is applied on entry, to all bits.
- Skew/deskew:
  - Chunks not yet consumed travel with the operation.
  - Finished result chunks travel with the operation to the output register.
  - Only chunks still needed are stored.
- Latency: exactly STAGES cycles from accepted input (valid_i & ready_o) to valid_o, with no stalls. Throughput is 1 op/cycle.
- Stall is global:
  - advance = !valid_o | ready_i, and ready_o = advance.
  - When advance=0, every stage holds. valid_o and all outputs must stay stable while valid_o & !ready_i.
- Operations leave in acceptance order. No drop or duplication without flush.
- Flush:
  - When flush_i=1, all stage valid bits clear on the next edge, so valid_o=0 the following cycle.
  - A valid_i in the same cycle is dropped. ready_o still reads 1 that cycle.
  - Data registers need not clear.
- flush_i together with ready_i=0: flush wins and the output is dropped.
- Reset mid-operation: all in-flight ops are lost and outputs return to reset values immediately (asynchronous).
- STAGES=1: a single registered adder with latency 1.
- Data registers load only when the stage advances with valid input. Bubbles may carry stale data with valid=0.

Optional Feature:
- Macro PIPE_ADDER_TAG_EN.
- Defined:
  - adds parameter TAG_WIDTH (default 4);
  - adds ports tag_i (in, TAG_WIDTH) and tag_o (out, TAG_WIDTH);
  - the tag is captured with the operation and emitted with its result;
  - tag_o resets to 0 and is stable under stall like the other outputs.
- Undefined: no tag parameter, ports or registers. Behaviour is otherwise identical.

Decomposition:
- riscv_pkg holds data_t (already present), plus a new typedef adder_stage_t packed struct {valid, carry, a_rem, b_rem, res_done}, sized from WIDTH by localparam inside the module, or a generic version with max widths.
- Localparam CW is derived in the module, not in the package.
- One sub-module, adder_chunk: combinational CW-bit add with carry in/out, also exporting the carry into its MSB for overflow. Instantiated once per stage via generate.

Test Plan:
Config WIDTH=32, STAGES=4.
- Carry chain: a=0xFFFFFFFF, b=0x00000001, cin=0, inv=0 -> 4 cycles later result=0x00000000, carry_out=1, overflow=0.
- Subtract: a=5, b=7, inv=1, cin=1 -> result=0xFFFFFFFE, carry_out=0, overflow=0. Then a=7, b=5 -> result=2, carry_out=1.
- Overflow: a=0x7FFFFFFF, b=1 -> 0x80000000, overflow=1, carry=0. Then a=0x80000000, b=0x80000000 -> 0, overflow=1, carry=1.
- Backpressure: 8 back-to-back ops a=i, b=i<<24, with ready_i low for 3 cycles while valid_o=1 -> ready_o low during the stall, outputs held stable, all 8 results in order, none lost.
- Flush: 3 ops in flight, flush_i=1 for one cycle together with valid_i=1 -> valid_o stays 0 for the following 4 cycles. The next op after the flush completes normally in 4 cycles.
- Reset: assert rst_ni=0 mid-stream, asynchronously off the clock edge -> valid_o, result_o, carry_out_o, overflow_o go to 0 immediately. After release the first new op returns after 4 cycles.
- With PIPE_ADDER_TAG_EN defined, additionally check tag_o matches tag_i per op across these cases.
